// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single memory port, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the LSU wins ties.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t   state, state_nxt;
  mem_req_t req_q;
  logic     last_grant;  // also the owner id of the outstanding transaction
  logic     grant_ifu, grant_lsu;
  logic     resp_hit;

  // Grants are held low during reset so no request is acknowledged but dropped.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE && !reset) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (ifu_req_valid && lsu_req_valid) begin
        grant_ifu = (last_grant == OWN_LSU);
        grant_lsu = (last_grant == OWN_IFU);
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
`else
      grant_lsu = lsu_req_valid;
      grant_ifu = ifu_req_valid && !lsu_req_valid;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_ifu || grant_lsu) state_nxt = REQ;
      REQ:     if (mem_req_ready)          state_nxt = WAIT;
      WAIT:    if (mem_resp_valid)         state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= '0;
      last_grant <= OWN_LSU;
    end else if (grant_lsu) begin
      req_q      <= '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
      last_grant <= OWN_LSU;
    end else if (grant_ifu) begin
      req_q      <= '{addr: ifu_addr, wen: 1'b0, wdata: 32'h0, wmask: 4'h0};
      last_grant <= OWN_IFU;
    end
  end

  // A memory response only counts while a transaction is waiting for it.
  always_comb begin
    resp_hit       = (state == WAIT) && mem_resp_valid;
    ifu_req_ready  = grant_ifu;
    lsu_req_ready  = grant_lsu;
    mem_req_valid  = (state == REQ);
    mem_addr       = req_q.addr;
    mem_wen        = req_q.wen;
    mem_wdata      = req_q.wdata;
    mem_wmask      = req_q.wmask;
    ifu_resp_valid = resp_hit && (last_grant == OWN_IFU);
    lsu_resp_valid = resp_hit && (last_grant == OWN_LSU);
    resp_rdata     = resp_hit ? mem_rdata : 32'h0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expected responses queue in a scoreboard drained by a monitor.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  typedef struct {
    logic        owner_lsu;
    logic [31:0] data;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && (ifu_resp_valid || lsu_resp_valid)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: ifu=%0b lsu=%0b expected no pulse", ifu_resp_valid, lsu_resp_valid);
      end else begin
        e = sb.pop_front();
        check("resp_owner", {30'h0, ifu_resp_valid, lsu_resp_valid}, e.owner_lsu ? 32'h1 : 32'h2);
        if (e.chk_data) check("resp_rdata", resp_rdata, e.data);
      end
    end
  end

  function automatic exp_t mk(input logic owner_lsu, input logic [31:0] data, input logic chk);
    exp_t x;
    x.owner_lsu = owner_lsu;
    x.data      = data;
    x.chk_data  = chk;
    return x;
  endfunction

  // Called one step after the accepting edge; stalls, accepts, then returns the response.
  task automatic mem_serve(input int stall, input logic [31:0] rd, input logic [31:0] a,
                           input logic wen, input logic [31:0] wd, input logic [3:0] wm);
    mem_req_ready = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) mem_req_ready = 1'b1;
      @(negedge clk);
      check("mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
      check("mem_addr", mem_addr, a);
      check("mem_wen", {31'h0, mem_wen}, {31'h0, wen});
      check("mem_wdata", mem_wdata, wd);
      check("mem_wmask", {28'h0, mem_wmask}, {28'h0, wm});
      check("ready_busy", {30'h0, ifu_req_ready, lsu_req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    @(negedge clk);
    check("mem_req_valid_wait", {31'h0, mem_req_valid}, 32'h0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
  endtask

  initial begin
    logic exp_lsu;
    reset = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h0;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;

    // Reset state: requests pending during reset must not be acknowledged.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {30'h0, ifu_req_ready, lsu_req_ready}, 32'h0);
    check("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_fields", {mem_wdata[30:0], mem_wen}, 32'h0);
    check("rst_resp", {30'h0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;

    // IFU fetch, minimum latency; arbitration in first cycle after release.
    @(posedge clk); #1;
    reset = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    @(negedge clk);
    check("ifu_accept", {30'h0, ifu_req_ready, lsu_req_ready}, 32'h2);
    sb.push_back(mk(1'b0, 32'h0000_0413, 1'b1));
    @(posedge clk); #1;
    ifu_req_valid = 1'b0; ifu_addr = 32'hFFFF_FFFC;
    mem_serve(0, 32'h0000_0413, 32'h8000_0000, 1'b0, 32'h0, 4'h0);

    // LSU store held through 3 stall cycles; requested at N+3 of the previous txn.
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    @(negedge clk);
    check("lsu_accept", {30'h0, ifu_req_ready, lsu_req_ready}, 32'h1);
    sb.push_back(mk(1'b1, 32'h0, 1'b0));
    @(posedge clk); #1;
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
    mem_serve(3, 32'hCAFE_F00D, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);

    // Stray memory response in IDLE is ignored; the next fetch works.
    mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_0001;
    @(negedge clk);
    check("stray_resp", {30'h0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
    check("stray_rdata", resp_rdata, 32'h0);
    check("stray_mem_req", {31'h0, mem_req_valid}, 32'h0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    @(negedge clk);
    check("post_stray_accept", {30'h0, ifu_req_ready, lsu_req_ready}, 32'h2);
    sb.push_back(mk(1'b0, 32'h0010_0093, 1'b1));
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    mem_serve(1, 32'h0010_0093, 32'h8000_0004, 1'b0, 32'h0, 4'h0);

    // Reset while in WAIT; late response after release must not be delivered.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
    @(negedge clk);
    check("pre_rst_accept", {30'h0, ifu_req_ready, lsu_req_ready}, 32'h2);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("wait_rst_mem_req", {31'h0, mem_req_valid}, 32'h0);
    check("wait_rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_0002;
    @(negedge clk);
    check("late_resp", {30'h0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_000C;
    @(negedge clk);
    check("post_rst_idle", {30'h0, ifu_req_ready, lsu_req_ready}, 32'h2);
    sb.push_back(mk(1'b0, 32'h0000_0013, 1'b1));
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    mem_serve(0, 32'h0000_0013, 32'h8000_000C, 1'b0, 32'h0, 4'h0);

    // Both requesting continuously; start from reset so last_grant is LSU.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_lsu = (k % 2 == 1);
`else
      exp_lsu = 1'b1;
`endif
      @(negedge clk);
      check($sformatf("grant_%0d", k), {30'h0, ifu_req_ready, lsu_req_ready}, exp_lsu ? 32'h1 : 32'h2);
      sb.push_back(mk(exp_lsu, 32'h0000_1000 + k, 1'b1));
      @(posedge clk); #1;
      mem_serve(0, 32'h0000_1000 + k, exp_lsu ? 32'h8000_2000 : 32'h8000_0100, 1'b0, 32'h0, 4'h0);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
